// File: rtl/axi_lite_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_reg_bank
//  Purpose  : AXI-Lite style register bank with DEPTH registers of
//             DATA_WIDTH bits each. The write address and write data
//             channels are accepted independently, in either order, and
//             held until the write commits. Reads return data one cycle
//             after the address handshake. Addresses >= DEPTH report an
//             error response and leave the registers untouched.
//  Macro    : AXI_LITE_STRB_EN - adds the wstrb byte-strobe port. Only
//             bytes whose strobe bit is set are written.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             waddr/wavalid/waready            - write address channel
//             wdata/[wstrb]/wvalid/wready      - write data channel
//             wresp/bvalid/bready              - write response channel
//             raddr/arvalid/arready            - read address channel
//             rdata/rresp/rvalid/rready        - read data channel
//             regs_o           - all registers, register i at
//                                [i*DATA_WIDTH +: DATA_WIDTH]
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_bank #(
    parameter int   DEPTH      = 32,
    parameter int   DATA_WIDTH = 32,
    localparam int  ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic                        wavalid,
    output logic                        waready,
    input  logic [DATA_WIDTH-1:0]       wdata,
`ifdef AXI_LITE_STRB_EN
    input  logic [DATA_WIDTH/8-1:0]     wstrb,
`endif
    input  logic                        wvalid,
    output logic                        wready,
    output logic                        wresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [ADDR_WIDTH-1:0]       raddr,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        rresp,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [DEPTH*DATA_WIDTH-1:0] regs_o
);

    // DEPTH always fits in ADDR_WIDTH+1 bits, so range checks use one
    // extra bit instead of a full 32-bit compare.
    localparam logic [ADDR_WIDTH:0] c_DEPTH  = DEPTH[ADDR_WIDTH:0];
    localparam logic                c_R_IDLE = 1'b0;
    localparam logic                c_R_DATA = 1'b1;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_regs;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_bvalid;
    logic                  r_wresp;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic                  w_wr_inrange;
    logic [ADDR_WIDTH-1:0] w_eff_addr;
    logic [DATA_WIDTH-1:0] w_eff_data;
    logic [DATA_WIDTH-1:0] w_wmask;

    assign waready = !r_aw_held && !r_bvalid;
    assign wready  = !r_w_held  && !r_bvalid;
    assign bvalid  = r_bvalid;
    assign wresp   = r_wresp;

    assign w_aw_hs = wavalid && waready;
    assign w_w_hs  = wvalid  && wready;

    // Held flags stay set while the response is pending, so the commit
    // must be gated by !r_bvalid to fire exactly once per write.
    assign w_commit   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
    assign w_eff_addr = r_aw_held ? r_awaddr : waddr;
    assign w_eff_data = r_w_held  ? r_wdata  : wdata;
    assign w_wr_inrange = ({1'b0, w_eff_addr} < c_DEPTH);

`ifdef AXI_LITE_STRB_EN
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [DATA_WIDTH/8-1:0] w_eff_strb;

    assign w_eff_strb = r_w_held ? r_wstrb : wstrb;

    for (genvar k = 0; k < DATA_WIDTH/8; k++) begin : g_strb
        assign w_wmask[k*8 +: 8] = {8{w_eff_strb[k]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstrb <= '0;
        end else if (w_w_hs && !w_commit) begin
            r_wstrb <= wstrb;
        end
    end
`else
    assign w_wmask = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_wresp   <= 1'b0;
        end else if (r_bvalid && bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else if (w_commit) begin
            // Keep both channels blocked until the response is taken.
            r_bvalid  <= 1'b1;
            r_wresp   <= !w_wr_inrange;
            r_aw_held <= 1'b1;
            r_w_held  <= 1'b1;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= waddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
            end
        end
    end

    // An out-of-range address matches no index, so nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_eff_addr == ADDR_WIDTH'(i)) begin
                    r_regs[i] <= (r_regs[i] & ~w_wmask) | (w_eff_data & w_wmask);
                end
            end
        end
    end

    assign regs_o = r_regs;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic                  r_rstate;
    logic                  w_rstate_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rresp;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_inrange;
    logic                  w_ar_hs;

    assign arready = (r_rstate == c_R_IDLE);
    assign rvalid  = (r_rstate == c_R_DATA);
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign w_ar_hs = arvalid && arready;
    assign w_rd_inrange = ({1'b0, raddr} < c_DEPTH);

    // Sampled from the current register contents, so a read on the same
    // edge as a write commit returns the pre-write value.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_WIDTH'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (arvalid) w_rstate_nxt = c_R_DATA;
            c_R_DATA: if (rready)  w_rstate_nxt = c_R_IDLE;
            default:               w_rstate_nxt = c_R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= c_R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= 1'b0;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_word;
            r_rresp <= !w_rd_inrange;
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_bank.md
AXI_LITE_REG_BANK -- requirements
Module: axi_lite_reg_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of registers; ADDR_WIDTH = $clog2(DEPTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register width in bits.
REQ-003 SHALL have ports, in this order:
- clk  in  1  the single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- waddr  in  ADDR_WIDTH  write address.
- wavalid  in  1  write address valid.
- waready  out  1  write address accepted.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  DATA_WIDTH/8  byte strobes; present only with AXI_LITE_STRB_EN.
- wvalid  in  1  write data valid.
- wready  out  1  write data accepted.
- wresp  out  1  write response: 0 = OKAY, 1 = error.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts the write response.
- raddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address accepted.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  1  read response: 0 = OKAY, 1 = error.
- rvalid  out  1  read data valid.
- rready  in  1  master accepts read data.
- regs_o  out  DEPTH*DATA_WIDTH  all registers, flattened; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-004 A handshake SHALL complete on a rising edge where valid and ready are both high.
REQ-005 The address and data channels SHALL be accepted independently, in either order or in the same cycle.
REQ-006 waready = !aw_held && !bvalid; an accepted address SHALL be held until the write commits.
REQ-007 wready = !w_held && !bvalid; accepted data (and strobes) SHALL be held until the write commits.
REQ-008 Write commit:
- occurs on the edge where both address and data are available, held or handshaking that edge;
- the register is updated on that edge;
- bvalid is high from the next cycle.
REQ-009 Write response:
- bvalid and wresp SHALL stay stable until the edge with bready high;
- that edge clears bvalid and both held flags;
- a new address or data handshake is possible from the following cycle.
REQ-010 A write with waddr >= DEPTH SHALL modify no register and SHALL return wresp = 1; otherwise wresp = 0.
REQ-011 Read channel states:
- R_IDLE: arready = 1, rvalid = 0.
- R_IDLE -> R_DATA on an arvalid handshake; rdata and rresp are registered on that edge.
- R_DATA: arready = 0, rvalid = 1; rdata and rresp stay stable.
- R_DATA -> R_IDLE on the edge with rready high.
- Read latency: 1 cycle from the address handshake to rvalid.
REQ-012 A read with raddr >= DEPTH SHALL return rdata = 0 and rresp = 1.
REQ-013 A read and a write committing to the same address on the same edge SHALL return the pre-write value; regs_o shows the new value from the next cycle.
REQ-014 The read and write channels SHALL operate concurrently and SHALL NOT stall each other.
REQ-015 A master may deassert rready or bready indefinitely without any response being lost or changed.

Reset
REQ-016 While rst is high at a rising edge, the next cycle SHALL show:
- all registers = 0, so regs_o = 0;
- bvalid = 0, rvalid = 0, wresp = 0, rresp = 0, rdata = 0;
- held flags cleared; read state = R_IDLE.
REQ-017 In the cycle after reset, waready = wready = arready = 1.
REQ-018 Reset asserted mid-transaction SHALL discard any held address or data and any pending response, with no register write.

Configuration
REQ-019 Macro AXI_LITE_STRB_EN:
- Defined: wstrb exists; DATA_WIDTH SHALL be a multiple of 8; only bytes with wstrb[k] = 1 are written, other bytes keep their value; an all-zero strobe on a valid address is a no-op with wresp = 0.
- Undefined: there is no wstrb port and every write updates the full word.

Verification
REQ-020 Write with reset value 0: waddr = 3 and wdata = 0xDEADBEEF in the same cycle, bready = 1 -> bvalid one cycle later, wresp = 0, regs_o word 3 = 0xDEADBEEF.
REQ-021 Data before address: wdata = 0x12345678 at cycle 0, waddr = 5 at cycle 4 -> wready = 0 during cycles 1-4, commit at cycle 4, bvalid at cycle 5, register 5 = 0x12345678.
REQ-022 Read backpressure: read raddr = 3 with rready = 0 for 6 cycles -> rvalid and rdata = 0xDEADBEEF stay stable and arready = 0 until rready = 1.
REQ-023 Out of range with DEPTH = 20: write to address 25 -> wresp = 1 and regs_o unchanged; read of address 25 -> rdata = 0, rresp = 1.
REQ-024 Strobes (AXI_LITE_STRB_EN): register 2 = 0xAABBCCDD, write 0x11223344 with wstrb = 4'b0101 -> register 2 = 0xAA22CC44.
REQ-025 Same-edge read and write: read register 2 on the same edge as a write to register 2 commits -> rdata returns the old value; an assertion of rst during a held address -> no write and bvalid = 0.
